mdu_alu_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer for the 16-bit pipeline.
- Performs unsigned 16x16 multiply with a 32-bit result, and unsigned 16/16 divide producing quotient and remainder.
- Iterates through the shared 16-bit ALU: one ALU operation per cycle, issued on the ALU-side ports.
- Sits beside EX. The hazard unit stalls on busy and writes hi/lo back on done.

---
 rtl/mdu_alu_sequencer_pkg.sv | 23 ++
 rtl/mdu_alu_sequencer.sv | 118 +++++++++++
 tb/tb_mdu_alu_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_alu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes, FSM
// state encoding and the divide-by-zero quotient constant.
package mdu_alu_sequencer_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_GT  = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) and restoring divide that issues
// one operation per cycle to an external combinational 16-bit ALU.
module mdu_alu_sequencer
  import mdu_alu_sequencer_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         isDiv,
  input  logic [N-1:0] opA,
  input  logic [N-1:0] opB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         divZero,
  output logic [2:0]   aluOp,
  output logic [N-1:0] aluA,
  output logic [N-1:0] aluB,
  input  logic [N-1:0] aluS,
  input  logic         aluCOut
);

  mdu_state_e       state_q, state_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_zero_q, div_zero_d;

  logic [2*N:0]     mul_shift;
  logic [N:0]       div_t;
  logic             take;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    aluOp      = ALU_ADD;
    aluA       = '0;
    aluB       = '0;
    // Partial remainder shifted left with the next dividend bit; bit N is t16.
    div_t      = {hi_q, lo_q[N-1]};
    take       = 1'b0;
    mul_shift  = {aluCOut, aluS, lo_q};

    case (state_q)
      ST_MUL: begin
        aluA  = hi_q;
        aluB  = lo_q[0] ? mcand_q : '0;
        hi_d  = mul_shift[2*N:N+1];
        lo_d  = mul_shift[N:1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N-1)) state_d = ST_DONE;
      end
      ST_DIV: begin
        aluOp = ALU_SUB;
        aluA  = div_t[N-1:0];
        aluB  = mcand_q;
        // A set t16 means the shifted remainder exceeds any N-bit divisor.
        take  = div_t[N] | aluCOut;
        hi_d  = take ? aluS : div_t[N-1:0];
        lo_d  = {lo_q[N-2:0], take};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N-1)) state_d = ST_DONE;
      end
      default: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          mcand_d    = opB;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (isDiv && (opB == '0)) begin
            state_d    = ST_DONE;
            lo_d       = N'(DIV_ZERO_QUOT);
            hi_d       = opA;
            div_zero_d = 1'b1;
          end else begin
            state_d = isDiv ? ST_DIV : ST_MUL;
            hi_d    = '0;
            lo_d    = opA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy    = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done    = (state_q == ST_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Directed bench for mdu_alu_sequencer with a behavioural 16-bit ALU wired to
// the alu* ports.
module tb_mdu_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        isDiv;
  logic [15:0] opA, opB;
  logic        busy, done, divZero;
  logic [15:0] hi, lo;
  logic [2:0]  aluOp;
  logic [15:0] aluA, aluB, aluS;
  logic        aluCOut;

  int tests = 0;
  int fails = 0;

  mdu_alu_sequencer #(.N(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .isDiv(isDiv), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero),
    .aluOp(aluOp), .aluA(aluA), .aluB(aluB), .aluS(aluS), .aluCOut(aluCOut)
  );

  always #5 clk = ~clk;

  // Reference ALU: add/sub with carry, sub carry = 1 when no borrow.
  always_comb begin
    aluS    = 16'h0000;
    aluCOut = 1'b0;
    case (aluOp)
      3'd0: {aluCOut, aluS} = {1'b0, aluA} + {1'b0, aluB};
      3'd1: {aluCOut, aluS} = {1'b0, aluA} + {1'b0, ~aluB} + 17'd1;
      3'd2: aluS = aluA & aluB;
      3'd3: aluS = aluA | aluB;
      3'd4: aluS = aluA ^ aluB;
      3'd5: aluS = {15'd0, aluA > aluB};
      3'd6: aluS = aluA << aluB[3:0];
      default: aluS = aluA >> aluB[3:0];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to done; lat is the edge index after E0 at
  // which done is first seen (-1 on timeout).
  task automatic run_op(input logic div, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output int alu_nz,
                        output logic [15:0] r_hi, output logic [15:0] r_lo,
                        output logic r_dz);
    lat = -1; busy_cnt = 0; alu_nz = 0; r_hi = 'x; r_lo = 'x; r_dz = 1'bx;
    @(negedge clk);
    start = 1'b1; isDiv = div; opA = a; opB = b;
    @(posedge clk);
    #1 start = 1'b0; opA = 16'hDEAD; opB = 16'hBEEF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (aluOp != 3'd0) alu_nz++;
      if (done) begin
        lat = k; r_hi = hi; r_lo = lo; r_dz = divZero;
        break;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; isDiv = 1'b0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, divZero, aluOp, hi, lo}, 32'd0);
    chk("reset_alu_ops", {aluA, aluB}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat, bc, anz; logic [15:0] h, l; logic dz;
    run_op(1'b0, 16'd3, 16'd5, lat, bc, anz, h, l, dz);
    chk("mul3x5_latency", lat, 16);
    chk("mul3x5_busy_cycles", bc, 16);
    chk("mul3x5_result", {h, l}, 32'h0000_000F);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, bc, anz, h, l, dz);
    chk("mulFFFF_result", {h, l}, 32'hFFFE_0001);
    chk("mulFFFF_latency", lat, 16);
  endtask

  task automatic test_divzero;
    int lat, bc, anz; logic [15:0] h, l; logic dz;
    run_op(1'b1, 16'h1234, 16'h0000, lat, bc, anz, h, l, dz);
    chk("div0_latency", lat, 0);
    chk("div0_result", {h, l}, 32'h1234_FFFF);
    chk("div0_flag", {31'd0, dz}, 32'd1);
    chk("div0_aluop_idle", anz, 0);
    chk("div0_flag_holds", {31'd0, divZero}, 32'd1);
  endtask

  task automatic test_div;
    int lat, bc, anz; logic [15:0] h, l; logic dz;
    run_op(1'b1, 16'd100, 16'd7, lat, bc, anz, h, l, dz);
    chk("div100_7_result", {h, l}, 32'h0002_000E);
    chk("div100_7_flag", {31'd0, dz}, 32'd0);
    chk("div100_7_latency", lat, 16);
    chk("div100_7_used_sub", {31'd0, anz > 0}, 32'd1);
    run_op(1'b1, 16'hFFFF, 16'h8001, lat, bc, anz, h, l, dz);
    chk("divFFFF_8001_result", {h, l}, 32'h7FFE_0001);
  endtask

  task automatic test_mid_reset;
    int lat, bc, anz, seen; logic [15:0] h, l; logic dz;
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; opA = 16'd3; opB = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, done, divZero, aluOp, hi, lo}, 32'd0);
    chk("midrst_alu_ops", {aluA, aluB}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run_op(1'b0, 16'd3, 16'd5, lat, bc, anz, h, l, dz);
    chk("midrst_then_mul", {h, l}, 32'h0000_000F);
  endtask

  task automatic test_start_busy;
    int lat;
    logic [31:0] res;
    lat = -1; res = '0;
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; opA = 16'd3; opB = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 4) begin start = 1'b1; isDiv = 1'b1; opA = 16'd700; opB = 16'd9; end
      if (k == 6) start = 1'b0;
      if (done) begin lat = k; res = {hi, lo}; break; end
    end
    start = 1'b0;
    chk("busy_start_ignored", res, 32'h0000_000F);
    chk("busy_start_latency", lat, 16);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [31:0] r1, r2;
    lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; opA = 16'h0012; opB = 16'h0034;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat1 = k; r1 = {hi, lo};
        start = 1'b1; isDiv = 1'b1; opA = 16'd100; opB = 16'd7;
        break;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_second_busy", {30'd0, busy, done}, 32'd2);
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (done) begin lat2 = k; r2 = {hi, lo}; break; end
    end
    chk("b2b_first_result", r1, 32'h0000_03A8);
    chk("b2b_first_latency", lat1, 16);
    chk("b2b_second_result", r2, 32'h0002_000E);
    chk("b2b_second_latency", lat2, 16);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divzero();
    test_div();
    test_mid_reset();
    test_start_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
